// File: rtl/instr_sequencer.sv
// Fetch/decode/execute control FSM for the 8-bit CPU model: owns the pc, fetches
// opcodes over req/ack, holds the IR for the Decoder and releases its control word for one cycle.
module instr_sequencer #(
  parameter int         PC_W    = 8,
  parameter int         CTRL_W  = 28,
  parameter logic [7:0] HALT_OP = 8'hFF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              run,
  output logic              mem_req,
  output logic [PC_W-1:0]   mem_addr,
  input  logic              mem_ack,
  input  logic [7:0]        mem_rdata,
  output logic [7:0]        ir,
  input  logic [CTRL_W-1:0] dec_ctrl,
  output logic [CTRL_W-1:0] ctrl_out,
  output logic              exec_en,
  input  logic              jump_en,
  input  logic [PC_W-1:0]   jump_addr,
  output logic [PC_W-1:0]   pc,
  output logic              halted,
  output logic [2:0]        state
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FETCH  = 3'd1,
    DECODE = 3'd2,
    EXEC   = 3'd3,
    WB     = 3'd4,
    HALT   = 3'd5
  } state_t;

  state_t            cur_state;
  state_t            nxt_state;
  logic [PC_W-1:0]   pc_q;
  logic [7:0]        ir_q;
  logic [CTRL_W-1:0] ctrl_q;
  logic              fetch_done;

  // An ack only counts while a fetch is outstanding.
  assign fetch_done = (cur_state == FETCH) && mem_ack;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cur_state <= IDLE;
    end else begin
      cur_state <= nxt_state;
    end
  end

  always_comb begin
    nxt_state = cur_state;
    case (cur_state)
      IDLE:    if (run) nxt_state = FETCH;
      FETCH:   if (mem_ack) nxt_state = DECODE;
      DECODE:  nxt_state = (ir_q == HALT_OP) ? HALT : EXEC;
      EXEC:    nxt_state = WB;
      WB:      nxt_state = run ? FETCH : IDLE;
      HALT:    nxt_state = HALT;
      default: nxt_state = IDLE;
    endcase
  end

  // A jump taken in EXEC overrides the increment made when that instruction was fetched.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc_q   <= '0;
      ir_q   <= '0;
      ctrl_q <= '0;
    end else begin
      if (fetch_done) begin
        ir_q <= mem_rdata;
        pc_q <= pc_q + PC_W'(1);
      end else if ((cur_state == EXEC) && jump_en) begin
        pc_q <= jump_addr;
      end
      if ((cur_state == DECODE) && (ir_q != HALT_OP)) begin
        ctrl_q <= dec_ctrl;
      end else if (cur_state == EXEC) begin
        ctrl_q <= '0;
      end
    end
  end

  always_comb begin
    mem_req  = (cur_state == FETCH);
    exec_en  = (cur_state == EXEC);
    halted   = (cur_state == HALT);
    ctrl_out = (cur_state == EXEC) ? ctrl_q : '0;
    mem_addr = pc_q;
    pc       = pc_q;
    ir       = ir_q;
    state    = cur_state;
  end

endmodule

// File: tb/tb_instr_sequencer.sv
// Bench for instr_sequencer: instruction memory with per-address ack delay, a Decoder
// stand-in, a cycle-level reference model checked every cycle, and directed scenarios.
module tb_instr_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        run;
  logic        mem_req;
  logic [7:0]  mem_addr;
  logic        mem_ack;
  logic [7:0]  mem_rdata;
  logic [7:0]  ir;
  logic [27:0] dec_ctrl;
  logic [27:0] ctrl_out;
  logic        exec_en;
  logic        jump_en;
  logic [7:0]  jump_addr;
  logic [7:0]  pc;
  logic        halted;
  logic [2:0]  state;

  logic [7:0]  mem [256];
  int          ack_delay_at [256];
  logic        stray_ack;
  int          waited = 0;
  int          cyc = 0;

  int          checks = 0;
  int          errors = 0;
  int          fetch_addr_q [$];
  int          fetch_cyc_q [$];
  logic [7:0]  exec_ir_q [$];
  logic [27:0] exec_ctrl_q [$];
  int          req_count = 0;
  int          req_addr1_count = 0;

  always #5 clk = ~clk;

  instr_sequencer dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .run       (run),
    .mem_req   (mem_req),
    .mem_addr  (mem_addr),
    .mem_ack   (mem_ack),
    .mem_rdata (mem_rdata),
    .ir        (ir),
    .dec_ctrl  (dec_ctrl),
    .ctrl_out  (ctrl_out),
    .exec_en   (exec_en),
    .jump_en   (jump_en),
    .jump_addr (jump_addr),
    .pc        (pc),
    .halted    (halted),
    .state     (state)
  );

  function automatic logic [27:0] decode_model(input logic [7:0] op);
    return {op, ~op, op ^ 8'h3C, 4'h9};
  endfunction

  assign dec_ctrl  = decode_model(ir);
  assign mem_rdata = mem[mem_addr];
  assign mem_ack   = (mem_req && (waited >= ack_delay_at[mem_addr])) || stray_ack;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (mem_req && !mem_ack) waited <= waited + 1;
    else waited <= 0;
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h required=%0h at cycle %0d", name, actual, expected, cyc);
    end
  endtask

  task automatic applyStimulus(input logic rn, input logic r, input logic je, input logic [7:0] ja);
    rst_n     = rn;
    run       = r;
    jump_en   = je;
    jump_addr = ja;
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic resetDut();
    applyStimulus(1'b0, 1'b0, 1'b0, 8'h00);
    stray_ack = 1'b0;
    step(2);
    fetch_addr_q.delete();
    fetch_cyc_q.delete();
    exec_ir_q.delete();
    exec_ctrl_q.delete();
    req_count       = 0;
    req_addr1_count = 0;
  endtask

  task automatic waitState(input logic [2:0] s, input logic use_ir, input logic [7:0] want_ir, input int limit);
    int  n = 0;
    logic hit;
    hit = (state == s) && (!use_ir || ir == want_ir);
    while (!hit && n < limit) begin
      step(1);
      n++;
      hit = (state == s) && (!use_ir || ir == want_ir);
    end
    checkOutput("wait_state", {31'd0, hit}, 32'd1);
  endtask

  // Reference model: instruction-level rules advanced once per cycle.
  initial begin : compare
    int         m_state;
    logic [7:0] m_pc;
    logic [7:0] m_ir;
    bit         m_valid;
    m_valid = 0;
    m_state = 0;
    m_pc    = 0;
    m_ir    = 0;
    forever begin
      @(negedge clk);
      if (m_valid) begin
        checkOutput("state",    32'(state),    32'(m_state));
        checkOutput("pc",       32'(pc),       32'(m_pc));
        checkOutput("mem_addr", 32'(mem_addr), 32'(m_pc));
        checkOutput("ir",       32'(ir),       32'(m_ir));
        checkOutput("mem_req",  32'(mem_req),  32'(m_state == 1));
        checkOutput("exec_en",  32'(exec_en),  32'(m_state == 3));
        checkOutput("halted",   32'(halted),   32'(m_state == 5));
        checkOutput("ctrl_out", 32'(ctrl_out), (m_state == 3) ? 32'(decode_model(m_ir)) : 32'd0);
      end
      if (rst_n === 1'b1) begin
        if (mem_req && mem_ack) begin
          fetch_addr_q.push_back(int'(mem_addr));
          fetch_cyc_q.push_back(cyc);
        end
        if (exec_en) begin
          exec_ir_q.push_back(ir);
          exec_ctrl_q.push_back(ctrl_out);
        end
        if (mem_req) req_count++;
        if (mem_req && mem_addr == 8'd1) req_addr1_count++;
      end
      if (rst_n !== 1'b1) begin
        m_valid = 1;
        m_state = 0;
        m_pc    = 0;
        m_ir    = 0;
      end else if (m_valid) begin
        case (m_state)
          0: if (run) m_state = 1;
          1: if (mem_ack) begin
               m_ir    = mem[m_pc];
               m_pc    = m_pc + 8'd1;
               m_state = 2;
             end
          2: m_state = (m_ir == 8'hFF) ? 5 : 3;
          3: begin
               if (jump_en) m_pc = jump_addr;
               m_state = 4;
             end
          4: m_state = run ? 1 : 0;
          default: m_state = 5;
        endcase
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int exp_a [3];
    int exp_j [8];
    for (int i = 0; i < 256; i++) begin
      mem[i]          = 8'h00;
      ack_delay_at[i] = 0;
    end
    applyStimulus(1'b0, 1'b0, 1'b0, 8'h00);
    stray_ack = 1'b0;

    // Zero-wait stream of three opcodes.
    mem[0] = 8'h00; mem[1] = 8'h01; mem[2] = 8'h C5; mem[3] = 8'h33;
    resetDut();
    applyStimulus(1'b1, 1'b1, 1'b0, 8'h00);
    step(12);
    exp_a = '{0, 1, 2};
    for (int i = 0; i < 3; i++)
      checkOutput("t1_fetch_addr", (i < fetch_addr_q.size()) ? fetch_addr_q[i] : -1, exp_a[i]);
    checkOutput("t1_period_a", (fetch_cyc_q.size() > 2) ? fetch_cyc_q[1] - fetch_cyc_q[0] : -1, 4);
    checkOutput("t1_period_b", (fetch_cyc_q.size() > 2) ? fetch_cyc_q[2] - fetch_cyc_q[1] : -1, 4);
    checkOutput("t1_exec_count", exec_ir_q.size(), 3);
    checkOutput("t1_exec_ir2", (exec_ir_q.size() > 2) ? 32'(exec_ir_q[2]) : -1, 32'hC5);
    checkOutput("t1_ctrl0", (exec_ctrl_q.size() > 0) ? 32'(exec_ctrl_q[0]) : -1, 32'h00FF3C9);
    checkOutput("t1_ctrl2", (exec_ctrl_q.size() > 2) ? 32'(exec_ctrl_q[2]) : -1, 32'hC53AF99);

    // Three-cycle ack delay on the fetch at address 1.
    resetDut();
    ack_delay_at[1] = 3;
    applyStimulus(1'b1, 1'b1, 1'b0, 8'h00);
    step(16);
    for (int i = 0; i < 3; i++)
      checkOutput("t2_fetch_addr", (i < fetch_addr_q.size()) ? fetch_addr_q[i] : -1, exp_a[i]);
    checkOutput("t2_period_slow", (fetch_cyc_q.size() > 2) ? fetch_cyc_q[1] - fetch_cyc_q[0] : -1, 7);
    checkOutput("t2_period_fast", (fetch_cyc_q.size() > 2) ? fetch_cyc_q[2] - fetch_cyc_q[1] : -1, 4);
    checkOutput("t2_req_cycles_addr1", req_addr1_count, 4);
    ack_delay_at[1] = 0;

    // Jump in EXEC is taken; a jump pulse in DECODE is not.
    resetDut();
    mem[4] = 8'h44; mem[5] = 8'h55; mem[6] = 8'h66;
    mem[8'h20] = 8'h60; mem[8'h21] = 8'h61; mem[8'h22] = 8'h62;
    applyStimulus(1'b1, 1'b1, 1'b0, 8'h00);
    waitState(3'd3, 1'b1, 8'h55, 40);
    applyStimulus(1'b1, 1'b1, 1'b1, 8'h20);
    step(1);
    applyStimulus(1'b1, 1'b1, 1'b0, 8'h00);
    waitState(3'd2, 1'b1, 8'h60, 20);
    checkOutput("t3_pc_after_jump_fetch", 32'(pc), 32'h21);
    applyStimulus(1'b1, 1'b1, 1'b1, 8'h40);
    step(1);
    applyStimulus(1'b1, 1'b1, 1'b0, 8'h00);
    step(8);
    exp_j = '{0, 1, 2, 3, 4, 5, 32, 33};
    for (int i = 0; i < 8; i++)
      checkOutput("t3_fetch_addr", (i < fetch_addr_q.size()) ? fetch_addr_q[i] : -1, exp_j[i]);

    // Halt opcode at address 3.
    resetDut();
    mem[3] = 8'hFF;
    applyStimulus(1'b1, 1'b1, 1'b0, 8'h00);
    waitState(3'd2, 1'b1, 8'hFF, 40);
    step(1);
    checkOutput("t4_state_halt", 32'(state), 32'd5);
    checkOutput("t4_halted", 32'(halted), 32'd1);
    step(20);
    checkOutput("t4_req_cycles", req_count, 4);
    checkOutput("t4_exec_count", exec_ir_q.size(), 3);
    checkOutput("t4_pc_frozen", 32'(pc), 32'd4);
    checkOutput("t4_still_halted", 32'(state), 32'd5);
    applyStimulus(1'b0, 1'b1, 1'b0, 8'h00);
    step(1);
    checkOutput("t4_reset_halted", 32'(halted), 32'd0);
    checkOutput("t4_reset_pc", 32'(pc), 32'd0);
    checkOutput("t4_reset_state", 32'(state), 32'd0);
    mem[3] = 8'h33;

    // Jump to the top of the address space wraps on the next fetch.
    resetDut();
    mem[8'hFF] = 8'h07;
    applyStimulus(1'b1, 1'b1, 1'b0, 8'h00);
    waitState(3'd3, 1'b1, 8'h00, 20);
    applyStimulus(1'b1, 1'b1, 1'b1, 8'hFF);
    step(1);
    applyStimulus(1'b1, 1'b1, 1'b0, 8'h00);
    waitState(3'd2, 1'b1, 8'h07, 20);
    checkOutput("t5_pc_wrap", 32'(pc), 32'd0);
    step(6);
    exp_a = '{0, 255, 0};
    for (int i = 0; i < 3; i++)
      checkOutput("t5_fetch_addr", (i < fetch_addr_q.size()) ? fetch_addr_q[i] : -1, exp_a[i]);

    // run dropped in EXEC, stray acks while idle, then reset mid-fetch.
    resetDut();
    mem[1] = 8'h42; mem[2] = 8'h99;
    applyStimulus(1'b1, 1'b1, 1'b0, 8'h00);
    waitState(3'd3, 1'b1, 8'h00, 20);
    applyStimulus(1'b1, 1'b0, 1'b0, 8'h00);
    stray_ack = 1'b1;
    step(1);
    checkOutput("t6_wb", 32'(state), 32'd4);
    step(1);
    checkOutput("t6_idle", 32'(state), 32'd0);
    step(5);
    checkOutput("t6_idle_hold", 32'(state), 32'd0);
    checkOutput("t6_pc_saved", 32'(pc), 32'd1);
    checkOutput("t6_req_cycles", req_count, 1);
    stray_ack = 1'b0;
    applyStimulus(1'b1, 1'b1, 1'b0, 8'h00);
    waitState(3'd2, 1'b1, 8'h42, 20);
    checkOutput("t6_resume_addr", (fetch_addr_q.size() > 1) ? fetch_addr_q[1] : -1, 1);
    ack_delay_at[2] = 5;
    waitState(3'd1, 1'b0, 8'h00, 10);
    step(1);
    applyStimulus(1'b0, 1'b1, 1'b0, 8'h00);
    stray_ack = 1'b1;
    step(1);
    stray_ack = 1'b0;
    checkOutput("t6_rst_state", 32'(state), 32'd0);
    checkOutput("t6_rst_mem_req", 32'(mem_req), 32'd0);
    checkOutput("t6_rst_ir", 32'(ir), 32'd0);
    checkOutput("t6_rst_pc", 32'(pc), 32'd0);
    checkOutput("t6_rst_ctrl", 32'(ctrl_out), 32'd0);
    checkOutput("t6_rst_exec", 32'(exec_en), 32'd0);
    applyStimulus(1'b1, 1'b0, 1'b0, 8'h00);
    step(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
